// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one memory port between an instruction-fetch requester and a data
//   (load/store) requester. A single transaction runs at a time through the
//   states IDLE -> REQ -> WAIT -> RESP -> IDLE. Data normally has priority;
//   a fairness bit hands the next grant to a fetch that was kept waiting
//   while a data transaction completed. A WAIT that never sees m_rvalid is
//   ended by a saturating 8-bit timeout counter, which returns zero data and
//   sets a sticky error flag.
//
// Ports
//   d_clk, d_rst          clock (rising edge), async active-low reset
//   i_req/i_addr          fetch request (held until i_done) and address
//   i_done/i_rdata        one-cycle fetch completion pulse and fetched word
//   d_req/d_we/d_mask/
//   d_addr/d_wdata        data request (held until d_done) and its fields
//   d_done/d_rdata        one-cycle data completion pulse and load data
//   m_req/m_we/m_mask/
//   m_addr/m_wdata        registered memory request fields
//   m_gnt                 memory accepts the request (sampled in REQ only)
//   m_rvalid/m_rdata      memory response (sampled in WAIT only)
//   o_stall_if/o_stall_mem combinational stage stalls
//   o_err                 sticky timeout flag
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              d_clk,
  input  logic              d_rst,
  input  logic              i_req,
  input  logic [AWIDTH-1:0] i_addr,
  output logic              i_done,
  output logic [DWIDTH-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_mask,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_done,
  output logic [DWIDTH-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_mask,
  output logic [AWIDTH-1:0] m_addr,
  output logic [DWIDTH-1:0] m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DWIDTH-1:0] m_rdata,
  output logic              o_stall_if,
  output logic              o_stall_mem,
  output logic              o_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t            state;
  logic              owner_data;   // 1 = current transaction belongs to data side
  logic              fair;         // next contested grant goes to fetch
  logic [7:0]        wait_cnt;

  logic              pick_data;
  logic              tmo_hit;
  logic [DWIDTH-1:0] resp_data;

  // NOTE: every signal written in always_comb gets a value on every path,
  // so no latch is inferred.
  always_comb begin
    pick_data = d_req & ~(i_req & fair);
    // This WAIT cycle without a response is the one that brings the
    // counter to TIMEOUT.
    tmo_hit   = ({1'b0, wait_cnt} + 9'd1) >= {1'b0, TMO};
    // A timed-out transaction returns zero data.
    resp_data = m_rvalid ? m_rdata : '0;
  end

  assign o_stall_if  = i_req & ~i_done;
  assign o_stall_mem = d_req & ~d_done;

  // NOTE: non-blocking assignments throughout, so every register here
  // samples the values from before the clock edge.
  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      state      <= IDLE;
      owner_data <= 1'b0;
      fair       <= 1'b0;
      wait_cnt   <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_mask     <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      o_err      <= 1'b0;
    end else begin
      // Completion pulses last exactly the single RESP cycle.
      i_done <= 1'b0;
      d_done <= 1'b0;

      case (state)
        IDLE: begin
          if (d_req || i_req) begin
            state      <= REQ;
            owner_data <= pick_data;
            m_req      <= 1'b1;
            wait_cnt   <= '0;
            if (pick_data) begin
              m_we    <= d_we;
              m_mask  <= d_mask;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
            end else begin
              m_we    <= 1'b0;
              m_mask  <= '0;
              m_addr  <= i_addr;
              m_wdata <= '0;
              fair    <= 1'b0;
            end
          end
        end

        REQ: begin
          // m_* stay untouched until the memory takes the request.
          if (m_gnt) begin
            state <= WAIT;
            m_req <= 1'b0;
          end
        end

        WAIT: begin
          if (!m_rvalid && wait_cnt != TMO) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
          if (m_rvalid || tmo_hit) begin
            state <= RESP;
            if (owner_data) begin
              d_done  <= 1'b1;
              d_rdata <= resp_data;
            end else begin
              i_done  <= 1'b1;
              i_rdata <= resp_data;
            end
            if (!m_rvalid) begin
              o_err <= 1'b1;
            end
          end
        end

        RESP: begin
          // A data transaction finishing under a waiting fetch hands the
          // next contested grant to the fetch.
          state <= IDLE;
          if (owner_data && i_req) begin
            fair <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Two requester processes replay queued
//   fetch / data requests with the hold-until-done handshake, a memory
//   responder grants and answers after programmable delays, and a
//   transaction-level model predicts every registered output. One compare
//   process checks the DUT against the model on every falling edge; the
//   main sequence adds hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int TO = 255;

  logic        d_clk = 1'b0;
  logic        d_rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_mask;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [3:0]  m_mask;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        o_stall_if;
  logic        o_stall_mem;
  logic        o_err;

  mem_arbiter #(.DWIDTH(32), .AWIDTH(32), .TIMEOUT(TO)) dut (
    .d_clk(d_clk), .d_rst(d_rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_mask(d_mask), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_mask(m_mask), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .o_stall_if(o_stall_if), .o_stall_mem(o_stall_mem), .o_err(o_err)
  );

  always #5 d_clk = ~d_clk;

  int cyc = 0;
  always @(posedge d_clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- checking
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ------------------------------------------------------------ requesters
  typedef struct {
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  logic [31:0] iq[$];
  dreq_t       dq[$];

  initial begin
    logic prev_done;
    i_req = 1'b0; i_addr = '0; prev_done = 1'b0;
    forever begin
      @(posedge d_clk); #1;
      if (!d_rst) begin
        i_req = 1'b0; prev_done = 1'b0;
      end else begin
        if (i_req && prev_done) i_req = 1'b0;
        if (!i_req && iq.size() > 0) begin
          i_addr = iq.pop_front();
          i_req  = 1'b1;
        end
        prev_done = i_done;
      end
    end
  end

  initial begin
    logic  prev_done;
    dreq_t r;
    d_req = 1'b0; d_we = 1'b0; d_mask = '0; d_addr = '0; d_wdata = '0;
    prev_done = 1'b0;
    forever begin
      @(posedge d_clk); #1;
      if (!d_rst) begin
        d_req = 1'b0; prev_done = 1'b0;
      end else begin
        if (d_req && prev_done) d_req = 1'b0;
        if (!d_req && dq.size() > 0) begin
          r       = dq.pop_front();
          d_we    = r.we;
          d_mask  = r.mask;
          d_addr  = r.addr;
          d_wdata = r.wdata;
          d_req   = 1'b1;
        end
        prev_done = d_done;
      end
    end
  end

  // ------------------------------------------------------ memory responder
  // Grants gnt_delay cycles after m_req rises, answers rv_delay cycles
  // after the grant (rv_delay < 0: never answers). resp_en=0 leaves m_gnt,
  // m_rvalid and m_rdata to the main sequence.
  bit          resp_en   = 1'b1;
  int          gnt_delay = 0;
  int          rv_delay  = 0;
  logic [31:0] rdata_val = '0;

  initial begin
    int rs_gcnt, rs_rcnt;
    bit rs_acc;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    rs_gcnt = 0; rs_rcnt = 0; rs_acc = 1'b0;
    forever begin
      @(posedge d_clk); #1;
      if (!d_rst) begin
        rs_gcnt = 0; rs_acc = 1'b0;
        if (resp_en) begin m_gnt = 1'b0; m_rvalid = 1'b0; end
      end else if (resp_en) begin
        m_gnt = 1'b0; m_rvalid = 1'b0;
        if (m_req) begin
          rs_acc = 1'b0;
          if (rs_gcnt == gnt_delay) begin
            m_gnt = 1'b1; rs_acc = 1'b1; rs_rcnt = 0; rs_gcnt = 0;
          end else rs_gcnt++;
        end else if (rs_acc) begin
          if (rv_delay >= 0 && rs_rcnt == rv_delay) begin
            m_rvalid = 1'b1; m_rdata = rdata_val; rs_acc = 1'b0;
          end
          rs_rcnt++;
        end
      end
    end
  end

  // ------------------------------------------------------------------ model
  // Tracks one outstanding transaction: whether it has been issued, accepted
  // by memory, and how long it has waited; outputs follow from those facts.
  logic        e_m_req, e_m_we, e_i_done, e_d_done, e_err;
  logic [3:0]  e_m_mask;
  logic [31:0] e_m_addr, e_m_wdata, e_i_rdata, e_d_rdata;
  bit          t_active, t_data, t_accepted, t_finishing, fair_m;
  int          t_waited;

  task automatic model_finish(input logic [31:0] v);
    t_finishing = 1'b1;
    if (t_data) begin e_d_done = 1'b1; e_d_rdata = v; end
    else        begin e_i_done = 1'b1; e_i_rdata = v; end
  endtask

  initial begin
    forever begin
      @(posedge d_clk or negedge d_rst);
      if (!d_rst) begin
        {e_m_req, e_m_we, e_i_done, e_d_done, e_err} = '0;
        e_m_mask = '0; e_m_addr = '0; e_m_wdata = '0;
        e_i_rdata = '0; e_d_rdata = '0;
        {t_active, t_data, t_accepted, t_finishing, fair_m} = '0;
        t_waited = 0;
      end else begin
        e_i_done = 1'b0; e_d_done = 1'b0;
        if (!t_active) begin
          if (d_req || i_req) begin
            t_data      = d_req && !(i_req && fair_m);
            t_active    = 1'b1;
            t_accepted  = 1'b0;
            t_finishing = 1'b0;
            t_waited    = 0;
            e_m_req     = 1'b1;
            if (t_data) begin
              e_m_we = d_we; e_m_mask = d_mask; e_m_addr = d_addr; e_m_wdata = d_wdata;
            end else begin
              e_m_we = 1'b0; e_m_mask = '0; e_m_addr = i_addr; e_m_wdata = '0;
              fair_m = 1'b0;
            end
          end
        end else if (t_finishing) begin
          if (t_data && i_req) fair_m = 1'b1;
          t_active = 1'b0;
        end else if (!t_accepted) begin
          if (m_gnt) begin t_accepted = 1'b1; e_m_req = 1'b0; end
        end else begin
          if (m_rvalid) model_finish(m_rdata);
          else begin
            t_waited++;
            if (t_waited >= TO) begin model_finish('0); e_err = 1'b1; end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- compare
  bit  started = 1'b0;
  byte done_log[$];

  always @(negedge d_clk) begin
    if (started) begin
      check("i_done", i_done, e_i_done);
      check("d_done", d_done, e_d_done);
      check("i_rdata", i_rdata, e_i_rdata);
      check("d_rdata", d_rdata, e_d_rdata);
      check("m_req", m_req, e_m_req);
      check("o_err", o_err, e_err);
      check("o_stall_if", o_stall_if, i_req & ~e_i_done);
      check("o_stall_mem", o_stall_mem, d_req & ~e_d_done);
      if (e_m_req) begin
        check("m_addr", m_addr, e_m_addr);
        check("m_we", m_we, e_m_we);
        check("m_mask", {28'd0, m_mask}, {28'd0, e_m_mask});
        if (e_m_we) check("m_wdata", m_wdata, e_m_wdata);
      end
      if (i_done) done_log.push_back(8'h49);  // 'I'
      if (d_done) done_log.push_back(8'h44);  // 'D'
    end
  end

  // ------------------------------------------------------------ sequencing
  task automatic wait_done(input string name, input bit data_side,
                           input int limit, output int at);
    at = -1;
    for (int k = 0; k < limit; k++) begin
      @(posedge d_clk); #2;
      if ((data_side ? d_done : i_done) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(posedge d_clk); #2;
      if (!i_req && !d_req && iq.size() == 0 && dq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, at, hi;

    d_rst = 1'b0;
    repeat (3) @(posedge d_clk);
    #2;
    check("rst_m_req", m_req, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_i_done", i_done, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_o_err", o_err, 0);
    @(negedge d_clk);
    d_rst   = 1'b1;
    started = 1'b1;
    repeat (2) @(posedge d_clk);
    #2;
    check("idle_no_req", m_req, 0);

    // Minimum-latency fetch: done exactly three cycles after the request.
    gnt_delay = 0; rv_delay = 0; rdata_val = 32'h20080005;
    iq.push_back(32'h10);
    @(posedge i_req);
    c0 = cyc;
    #1 check("f_stall_c0", o_stall_if, 1);
    @(posedge d_clk); #2;
    check("f_m_req_c1", m_req, 1);
    check("f_m_addr_c1", m_addr, 32'h10);
    check("f_m_we_c1", m_we, 0);
    check("f_stall_c1", o_stall_if, 1);
    @(posedge d_clk); #2;
    check("f_stall_c2", o_stall_if, 1);
    check("f_done_c2", i_done, 0);
    wait_done("f_done", 1'b0, 10, at);
    check("f_latency", at - c0, 3);
    check("f_rdata", i_rdata, 32'h20080005);
    check("f_stall_c3", o_stall_if, 0);
    wait_idle("f", 20);

    // Simultaneous store and fetch: store first, then the fetch.
    done_log.delete();
    gnt_delay = 0; rv_delay = 1; rdata_val = 32'h0BADF00D;
    dq.push_back('{1'b1, 4'b1111, 32'h40, 32'hDEADBEEF});
    iq.push_back(32'h44);
    @(posedge d_req);
    @(posedge d_clk); #2;
    check("both_m_we", m_we, 1);
    check("both_m_addr", m_addr, 32'h40);
    check("both_m_wdata", m_wdata, 32'hDEADBEEF);
    check("both_m_mask", {28'd0, m_mask}, 32'hF);
    wait_done("both_d", 1'b1, 20, at);
    check("both_i_not_yet", i_done, 0);
    wait_idle("both", 40);
    check("both_log_len", done_log.size(), 2);
    check("both_log0", {24'd0, done_log[0]}, 32'h44);
    check("both_log1", {24'd0, done_log[1]}, 32'h49);

    // Back-to-back loads with fetch held: only one load before the fetch.
    done_log.delete();
    gnt_delay = 1; rv_delay = 2; rdata_val = 32'hCAFE0001;
    dq.push_back('{1'b0, 4'b0000, 32'h100, 32'h0});
    dq.push_back('{1'b0, 4'b0000, 32'h104, 32'h0});
    iq.push_back(32'h300);
    wait_idle("b2b", 80);
    check("b2b_log_len", done_log.size(), 3);
    check("b2b_log0", {24'd0, done_log[0]}, 32'h44);
    check("b2b_log1", {24'd0, done_log[1]}, 32'h49);
    check("b2b_log2", {24'd0, done_log[2]}, 32'h44);
    check("b2b_d_rdata", d_rdata, 32'hCAFE0001);

    // Grant withheld for five REQ cycles: request fields stay put.
    gnt_delay = 5; rv_delay = 0; rdata_val = 32'h00000077;
    dq.push_back('{1'b1, 4'b0011, 32'h80, 32'h12345678});
    @(posedge d_req);
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge d_clk); #2;
      if (!m_req) break;
      hi++;
      check("hold_m_addr", m_addr, 32'h80);
      check("hold_m_wdata", m_wdata, 32'h12345678);
    end
    check("hold_req_cycles", hi, 6);
    wait_idle("hold", 20);

    // Stray m_gnt / m_rvalid while idle are ignored.
    resp_en = 1'b0;
    @(posedge d_clk); #1;
    m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hFFFFFFFF;
    repeat (2) @(posedge d_clk);
    #1;
    m_gnt = 1'b0; m_rvalid = 1'b0;
    #1;
    check("stray_m_req", m_req, 0);
    check("stray_d_done", d_done, 0);
    check("stray_i_rdata", i_rdata, 32'hCAFE0001);
    resp_en = 1'b1;

    // Memory never answers: timeout after 255 WAIT cycles, zero data.
    gnt_delay = 0; rv_delay = -1;
    iq.push_back(32'h500);
    @(posedge i_req);
    c0 = cyc;
    wait_done("tmo", 1'b0, 600, at);
    check("tmo_latency", at - c0, 257);
    check("tmo_rdata", i_rdata, 0);
    check("tmo_err", o_err, 1);
    wait_idle("tmo", 20);
    rv_delay = 0; rdata_val = 32'h00005555;
    iq.push_back(32'h504);
    wait_idle("tmo_after", 20);
    check("tmo_err_sticky", o_err, 1);

    // Reset while waiting: transaction abandoned, late m_rvalid ignored.
    gnt_delay = 0; rv_delay = -1;
    iq.push_back(32'h600);
    @(posedge i_req);
    repeat (3) @(posedge d_clk);
    #2;
    d_rst = 1'b0;
    #1;
    check("ar_m_req", m_req, 0);
    check("ar_m_addr", m_addr, 0);
    check("ar_i_rdata", i_rdata, 0);
    check("ar_o_err", o_err, 0);
    @(posedge d_clk);
    @(negedge d_clk);
    resp_en = 1'b0;
    d_rst   = 1'b1;
    @(posedge d_clk); #1;
    m_rvalid = 1'b1; m_rdata = 32'h00000BAD;
    @(posedge d_clk); #1;
    m_rvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge d_clk); #2;
      check("ar_no_done", i_done, 0);
      check("ar_rdata_clr", i_rdata, 0);
    end
    resp_en = 1'b1; rv_delay = 0; rdata_val = 32'h0000600D;
    iq.push_back(32'h700);
    wait_done("ar_next", 1'b0, 20, at);
    check("ar_next_rdata", i_rdata, 32'h0000600D);
    check("ar_next_err", o_err, 0);
    wait_idle("ar_next", 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
